// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C temperature-sensor responder.
//   state_t        - responder state encoding
//   I2C_ADDR_TEMP  - default 7-bit bus address of the emulated sensor
//   BYTE_BITS      - bit-counter terminal value for one byte
//   is_read_header - true when a header byte addresses us with R/W=1
package i2c_pkg;

    localparam logic [6:0] I2C_ADDR_TEMP = 7'h4B;
    localparam logic [3:0] BYTE_BITS     = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        TX_M,
        MACK_M,
        TX_L,
        MACK_L,
        WAIT_STOP
    } state_t;

    function automatic logic is_read_header(input logic [7:0] hdr,
                                            input logic [6:0] addr);
        return (hdr[7:1] == addr) && hdr[0];
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings one asynchronous bus line into the clk domain and
// produces single-clk edge strobes.
//   clk, rst_n - system clock, async active-low reset
//   line       - raw pin level
//   level      - synchronized level
//   rise, fall - one-clk strobes on synchronized level transitions
// All flops reset to 1, the idle level of an open-drain bus, so leaving
// reset never fabricates an edge.
module i2c_line_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_temp_slave.sv
// i2c_temp_slave: read-only two-byte temperature sensor emulation on I2C.
//   clk, rst_n         - system clock, async active-low reset
//   scl                - bus clock from the master
//   sda                - open-drain data; driven 0 or released
//   temp_msb, temp_lsb - bytes returned, snapshotted at address ACK
//   busy               - high from address ACK until STOP / repeated START
//   rd_done            - one-clk pulse on the master's ACK bit of byte 2
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the header byte
// ACK_A     | driving the address ACK
// TX_M      | shifting out the MSB byte
// MACK_M    | master ACK/NACK slot after the MSB
// TX_L      | shifting out the LSB byte
// MACK_L    | master ACK/NACK slot after the LSB
// WAIT_STOP | released, waiting for STOP or repeated START
module i2c_temp_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = I2C_ADDR_TEMP,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] temp_msb,
    input  logic [7:0] temp_lsb,
    output logic       busy,
    output logic       rd_done
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [7:0]  hdr_q;
    logic [15:0] tx_q;
    logic        sda_oe;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (sda),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // Both lines share the same synchronizer depth, so scl_lvl is aligned
    // with the SDA edge strobes.
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            hdr_q   <= '0;
            tx_q    <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise && bit_cnt != BYTE_BITS) begin
                            hdr_q   <= {hdr_q[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == BYTE_BITS) begin
                            if (is_read_header(hdr_q, SLAVE_ADDR)) begin
                                sda_oe <= 1'b1;
                                tx_q   <= {temp_msb, temp_lsb};
                                busy   <= 1'b1;
                                state  <= ACK_A;
                            end else begin
                                state  <= WAIT_STOP;
                            end
                        end
                    end
                    ACK_A, MACK_M: begin
                        // MACK_M only reaches its scl_fall after an ACK;
                        // a NACK leaves on the preceding scl_rise.
                        if (state == MACK_M && scl_rise && sda_lvl) begin
                            state <= WAIT_STOP;
                        end else if (scl_fall) begin
                            sda_oe  <= ~tx_q[15];
                            tx_q    <= {tx_q[14:0], 1'b1};
                            bit_cnt <= 4'd1;
                            state   <= (state == ACK_A) ? TX_M : TX_L;
                        end
                    end
                    TX_M, TX_L: begin
                        if (scl_fall) begin
                            if (bit_cnt == BYTE_BITS) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= (state == TX_M) ? MACK_M : MACK_L;
                            end else begin
                                sda_oe  <= ~tx_q[15];
                                tx_q    <= {tx_q[14:0], 1'b1};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    MACK_L: begin
                        if (scl_rise) begin
                            rd_done <= 1'b1;
                            state   <= WAIT_STOP;
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_temp_slave.md
Name: i2c_temp_slave

Overview:
- I2C responder emulating the two-byte read-only temperature sensor at 7-bit address 0x4B, for use in simulation and on-board loopback.
- Oversamples SCL/SDA on the system clock.
- Acknowledges its read address, then shifts out a snapshot of temp_msb followed by temp_lsb.
- Sits on the same open-drain SCL/SDA pair as the sensor-reading master.

Parameters:
- SLAVE_ADDR, 7'h4B, 7-bit bus address answered.
- SYNC_STAGES, 2, flops in each of the SCL and SDA synchronizers (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- scl  input  1  I2C clock, driven by the master
- sda  inout  1  I2C data, open-drain: this block only drives 0 or releases to z
- temp_msb  input  8  first byte returned
- temp_lsb  input  8  second byte returned
- busy  output  1  high from address ACK until STOP or repeated START
- rd_done  output  1  one-clk pulse after the master's ACK/NACK bit for the second byte

Behaviour:
- **Reset values:** sda released (sda_oe=0), busy=0, rd_done=0, state IDLE, synchronizer flops=1. Reset is asynchronous, so a reset mid-transfer releases sda immediately.
- **Synchronization:** SCL and SDA each pass through a SYNC_STAGES synchronizer, followed by one extra flop for edge detection.
  - Edge strobes: scl_rise, scl_fall, start_det (SDA fall while SCL high), stop_det (SDA rise while SCL high).
- **Timing requirements:**
  - SCL high and low phases must each be at least SYNC_STAGES+4 clk.
  - The master changes SDA only while SCL is low, at least 1 clk after the SCL fall.
- **Bit timing:**
  - Input bits are sampled on scl_rise.
  - Output changes on scl_fall, i.e. SYNC_STAGES+1 clk after the pin edge.
- **State machine:**
  - IDLE: on start_det -> ADDR, bit count 0.
  - ADDR: shift in 8 bits MSB first. After the 8th scl_rise, compare.
    - [7:1]==SLAVE_ADDR and [0]==1: on the next scl_fall drive sda low, snapshot temp_msb/temp_lsb into a 16-bit shift register, set busy -> ACK_A.
    - Otherwise: stay released -> WAIT_STOP. Write transactions are NACKed.
  - ACK_A: on scl_fall, drive MSB bit 7 (drive low if 0, release if 1) -> TX_M.
  - TX_M: each scl_fall presents the next bit. After 8 bits have been presented, the scl_fall that ends bit 0 releases sda -> MACK_M.
  - MACK_M: sample on scl_rise.
    - Sampled 0 (ACK): on scl_fall drive LSB bit 7 -> TX_L.
    - Sampled 1 (NACK): remain released -> WAIT_STOP.
  - TX_L: same as TX_M using the LSB byte, then -> MACK_L.
  - MACK_L: sample on scl_rise, pulse rd_done on that clk, then release -> WAIT_STOP, whatever the ACK value. Reads longer than 2 bytes are not supported; further clocks read 1s.
  - WAIT_STOP: sda released; waits for stop_det or start_det.
- **Start/stop priority:**
  - stop_det in any state -> IDLE, sda released, busy=0.
  - start_det in any state (repeated START) -> ADDR, busy=0, sda released.
  - start/stop detection takes priority over bit handling in the same clk.
- **Snapshot:** the temp_* inputs may change during a transfer without affecting the bytes being sent. A new snapshot is taken only at the next address ACK.
- **Bit counter:** 4 bits; saturates at 8. It does not wrap.

Decomposition:
- **Package i2c_pkg:**
  - state encoding constants: IDLE, ADDR, ACK_A, TX_M, MACK_M, TX_L, MACK_L, WAIT_STOP.
  - I2C_ADDR_TEMP = 7'h4B.
- **Sub-module i2c_line_sync:** one instance per line. Synchronizer plus edge detector, outputting the synced level, rise and fall.

Test Plan:
- **Nominal read:** reset, temp_msb=8'h19, temp_lsb=8'h80. Bus model at 400 clk per SCL period sends START, 0x97, ACK after the MSB, NACK after the LSB, STOP -> slave ACKs the address; master reads 0x19 then 0x80; rd_done pulses once; busy falls at STOP.
- **Wrong address:** header 0x91 -> sda is never driven low, busy stays 0, state returns to IDLE at STOP.
- **Write direction:** header 0x96 -> NACK, nothing driven until STOP.
- **Master NACK after MSB:** temp_msb=8'hA5, master NACKs byte 1 -> reads 0xA5; sda released for the rest of the transfer; no rd_done.
- **Snapshot:** temp_msb changes from 8'h10 to 8'h7F during TX_M -> master still reads 0x10; the next transaction reads 0x7F.
- **Repeated START / reset:** repeated START mid-TX_L is followed by a valid header -> fresh ACK and correct bytes. Asserting rst_n=0 while sda is driven low -> sda becomes z in the same clk.
